lb_reg_responder: RTL
=====================

# lb_reg_responder

Local-bus responder for the oscope application: the target side of the 24-bit-address / 32-bit-data local bus issued by `marble_base`. It decodes a 64-word window and provides eight read/write control registers with write strobes and eight read-only status words. It also provides an ID word, a free-running cycle counter, a pop-on-read data port for an external FIFO, and a bad-access counter. Read data returns on a fixed-latency pipeline, so back-to-back reads are sustained at one per cycle. It sits inside `application_top`, and its `lb_din` is ORed with other responders.

## Interface
Parameters:
- `BASE_ADDR`, 24'h010000, window base; bits [5:0] are ignored.
- `READ_LAT`, 3, cycles from read issue to `lb_din_valid`; legal range 1..8.
- `ID_WORD`, 32'h6f73636f, constant returned at offset 0x10.

Ports:
- `lb_clk`, in, 1, the single clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `lb_addr`, in, 24, word address.
- `lb_strobe`, in, 1, transaction valid.
- `lb_rd`, in, 1, read qualifier.
- `lb_write`, in, 1, write qualifier.
- `lb_data`, in, 32, write data.
- `lb_din`, out, 32, read data; 0 when not valid.
- `lb_din_valid`, out, 1, read data valid.
- `ctl_reg`, out, 256, eight control words; word k is bits [32k+31:32k].
- `ctl_wstb`, out, 8, one-cycle write pulse for each control word.
- `status_in`, in, 256, eight status words.
- `fifo_data`, in, 32, head of the external FIFO.
- `fifo_valid`, in, 1, FIFO non-empty.
- `fifo_pop`, out, 1, one-cycle pop request.

## Operation
- Hit: `lb_addr[23:6] == BASE_ADDR[23:6]`. Offset is `lb_addr[5:0]`.
- Write: `lb_strobe & lb_write & hit`.
- Read issue: `lb_strobe & lb_rd & !lb_write & hit`.
  - When `lb_rd` and `lb_write` are both high, the cycle is a write only.
  - Non-hit cycles are ignored entirely.
- Memory map (by offset):
  - 0x00–0x07: `ctl_reg[k]`, R/W.
  - 0x08–0x0F: `status_in[k]`, RO.
  - 0x10: `ID_WORD`, RO.
  - 0x11: cycle counter, RO.
  - 0x12: FIFO data, RO, pops.
  - 0x13: FIFO status, RO; bit0 = `fifo_valid`, other bits 0.
  - 0x14: bad-access counter, RO; any write clears it.
  - All other offsets: read 0.
- Cycle counter: 32-bit, increments every cycle, wraps from 0xFFFFFFFF to 0. A read returns its value in the issue cycle.
- FIFO read (offset 0x12):
  - With `fifo_valid=1` at issue: return `fifo_data` sampled at issue, and assert `fifo_pop` for one cycle.
  - With `fifo_valid=0` at issue: return 0 and do not pop.
- Status words and `fifo_valid` are sampled in the issue cycle.
- Bad-access counter: 16-bit, saturates at 0xFFFF. It increments on a write to offsets 0x08–0x13 or 0x15–0x3F.
  - A write to 0x14 clears it. Clear takes priority over any increment in the same cycle.
- Read data for a given issue is fixed at issue. A write in the next cycle does not alter the in-flight data.
- Read pipeline: `READ_LAT`-deep shift of {valid, data}. No stalls and no reordering.

## Timing
- Reset values (asynchronous assertion of `rst_n=0`):
  - All of `ctl_reg`, the counters and the pipeline clear to 0.
  - `ctl_wstb`, `fifo_pop`, `lb_din_valid` and `lb_din` are 0.
- Reset mid-operation discards in-flight reads; no `lb_din_valid` occurs for them.
- Writes:
  - A write in cycle N updates `ctl_reg[k]` at the edge ending cycle N, so it is visible in cycle N+1.
  - `ctl_wstb[k]` is high in cycle N+1 only.
  - Back-to-back writes to the same register pulse `ctl_wstb` in consecutive cycles.
- Reads:
  - A read issued in cycle N gives `lb_din_valid=1` and data in cycle N+`READ_LAT`, for one cycle only.
  - A read of offset 0x00–0x07 issued in cycle N+1 after a write in cycle N returns the new value.
  - `fifo_pop` is registered: it is high in cycle N+1 for a qualifying read issued in cycle N.
  - Consecutive FIFO reads each sample `fifo_valid`/`fifo_data` in their own issue cycle. The FIFO must update its head within one cycle of a pop.
- `lb_din` is exactly 0 whenever `lb_din_valid=0`, for safe OR-combining.

## Test plan
- **Reset values:** release reset, then read 0x10 and 0x00 → `ID_WORD` then 0, each exactly 3 cycles after issue; `ctl_wstb` stays 0.
- **Write/readback:**
  - Write 0xA5A5_0001 to 0x03 → `ctl_wstb[3]` pulses one cycle and `ctl_reg[3]` = 0xA5A5_0001.
  - An immediate read of 0x03 returns it.
  - A write to an address outside the window changes nothing.
- **Back-to-back reads:** issue reads of 0x08–0x0F in eight consecutive cycles with `status_in[k]=k+0x100` → eight consecutive valid cycles returning 0x100..0x107 in order.
- **FIFO:**
  - With `fifo_valid=1` and data 0x1234, read 0x12 → 0x1234 returned and one `fifo_pop` pulse.
  - With `fifo_valid=0`, read 0x12 → 0 returned, no pop.
  - Read 0x13 → bit0 tracks `fifo_valid`.
- **Bad-access counter:** three writes to 0x20 → read 0x14 returns 3. Write 0x14 → 0. Force the count to 0xFFFF (or issue 65 540 bad writes) → the count stays at 0xFFFF.
- **Reset mid-read and counter wrap:**
  - Issue a read, then assert `rst_n=0` one cycle later → no `lb_din_valid` appears.
  - Cycle counter reads taken 5 cycles apart differ by 5, including across the wrap.

Source files
------------

// File: rtl/lb_reg_responder.sv
// Local-bus target for the oscope application: control/status register window,
// ID word, cycle counter, FIFO pop port and bad-access counter, fixed-latency reads.
module lb_reg_responder #(
    parameter logic [23:0] BASE_ADDR = 24'h010000,
    parameter int          READ_LAT  = 3,
    parameter logic [31:0] ID_WORD   = 32'h6f73636f
) (
    input  logic         lb_clk,
    input  logic         rst_n,
    input  logic [23:0]  lb_addr,
    input  logic         lb_strobe,
    input  logic         lb_rd,
    input  logic         lb_write,
    input  logic [31:0]  lb_data,
    output logic [31:0]  lb_din,
    output logic         lb_din_valid,
    output logic [255:0] ctl_reg,
    output logic [7:0]   ctl_wstb,
    input  logic [255:0] status_in,
    input  logic [31:0]  fifo_data,
    input  logic         fifo_valid,
    output logic         fifo_pop
);

    logic             hit;
    logic [5:0]       off;
    logic             wr_en;
    logic             rd_en;
    logic             ctl_sel;
    logic             bad_off;
    logic [7:0][31:0] ctl_q;
    logic [7:0][31:0] status_w;
    logic [31:0]      cycle_cnt;
    logic [15:0]      bad_cnt;
    logic [31:0]      rd_data;

    logic [READ_LAT-1:0] pipe_v;
    logic [31:0]         pipe_d [READ_LAT];

    assign hit      = (lb_addr[23:6] == BASE_ADDR[23:6]);
    assign off      = lb_addr[5:0];
    // A cycle with both qualifiers high is treated as a write only.
    assign wr_en    = lb_strobe & lb_write & hit;
    assign rd_en    = lb_strobe & lb_rd & ~lb_write & hit;
    assign ctl_sel  = (off[5:3] == 3'd0);
    assign bad_off  = ((off >= 6'h08) && (off <= 6'h13)) || (off >= 6'h15);
    assign status_w = status_in;
    assign ctl_reg  = ctl_q;

    always_comb begin
        rd_data = '0;
        if (off[5:3] == 3'd0) begin
            rd_data = ctl_q[off[2:0]];
        end else if (off[5:3] == 3'd1) begin
            rd_data = status_w[off[2:0]];
        end else begin
            case (off)
                6'h10:   rd_data = ID_WORD;
                6'h11:   rd_data = cycle_cnt;
                6'h12:   rd_data = fifo_valid ? fifo_data : 32'd0;
                6'h13:   rd_data = {31'd0, fifo_valid};
                6'h14:   rd_data = {16'd0, bad_cnt};
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q    <= '0;
            ctl_wstb <= '0;
        end else begin
            ctl_wstb <= '0;
            if (wr_en && ctl_sel) begin
                ctl_q[off[2:0]] <= lb_data;
                ctl_wstb        <= 8'd1 << off[2:0];
            end
        end
    end

    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            bad_cnt   <= '0;
            fifo_pop  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            fifo_pop  <= rd_en && (off == 6'h12) && fifo_valid;
            if (wr_en && (off == 6'h14)) begin
                bad_cnt <= '0;
            end else if (wr_en && bad_off && (bad_cnt != 16'hFFFF)) begin
                bad_cnt <= bad_cnt + 16'd1;
            end
        end
    end

    // Data is captured at issue, so later writes cannot disturb an in-flight read.
    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_en;
            pipe_d[0] <= rd_en ? rd_data : 32'd0;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign lb_din_valid = pipe_v[READ_LAT-1];
    assign lb_din       = pipe_v[READ_LAT-1] ? pipe_d[READ_LAT-1] : 32'd0;

endmodule
